param_regfile: RTL
==================

Name: param_regfile

Overview:
- Parametrised successor to the single-cycle MIPS 8x8 register file. It provides configurable width and depth, two asynchronous read ports, one synchronous write port, an optional hardwired-zero register and optional write-to-read bypass.
- It adds a run-time bulk-clear engine: a one-register-per-cycle state machine with busy/done handshake.
- It sits in the datapath between decode (ra1/ra2/wa) and writeback (wd). It also sits on the board test harness, driven from switches.

Parameters:
- W, 8, data width in bits.
- AW, 3, address width; DEPTH = 2**AW registers.
- ZERO_REG, 1, if 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, if 1, a same-cycle write to the addressed register is forwarded to the read port.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  W  write data.
- ra1  in  AW  read address port 1.
- ra2  in  AW  read address port 2.
- rd1  out  W  read data port 1, combinational.
- rd2  out  W  read data port 2, combinational.
- clr_req  in  1  request bulk clear; sampled only in IDLE.
- busy  out  1  high while clear sweep in progress.
- clr_done  out  1  one-cycle pulse when sweep completes.
- wr_drop  out  1  high in any cycle a write is discarded because busy=1.

Behaviour:
- Reset (clk edge with reset=1):
  - all DEPTH registers <= 0.
  - state <= IDLE, ptr <= 0.
  - busy=0, clr_done=0.
  - Reset overrides clr_req, we and an in-progress sweep.
- Write: on clk edge with we=1, busy=0, reset=0: regs[wa] <= wd.
  - If ZERO_REG=1 and wa=0: no update.
- Read:
  - rdN = regs[raN], combinational, zero latency.
  - If ZERO_REG=1 and raN=0: rdN = 0 regardless of contents or bypass.
  - If BYPASS=1, we=1, busy=0 and wa=raN (and not the zero-reg case): rdN = wd.
  - If BYPASS=0: the new value is visible the cycle after the write edge.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE: busy=0, clr_done=0. If clr_req=1, go to CLEAR with ptr <= 0.
  - CLEAR: busy=1. Each edge: regs[ptr] <= 0, ptr <= ptr+1. When ptr = DEPTH-1 is cleared, go to DONE.
  - DONE: busy=0, clr_done=1 for exactly one cycle, then IDLE.
- Clear timing: a request sampled at edge N gives busy=1 for cycles N+1..N+DEPTH and clr_done=1 in cycle N+DEPTH+1.
- clr_req is ignored in CLEAR and DONE. It is not queued; the requester must reassert in IDLE.
- Writes while busy=1:
  - discarded; wr_drop = we & busy, combinational.
  - no bypass applied to the dropped data.
- Reads during CLEAR return current contents. Registers with index < ptr read 0; others hold old values.
- ptr wraps naturally at DEPTH (AW bits); no separate overflow handling.
- Simultaneous reset and clr_req: reset wins, FSM stays IDLE.

Decomposition:
- Shared package regfile_pkg holds:
  - typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t.
  - default localparams REGFILE_W=8, REGFILE_AW=3.
- Sub-module regfile_clr_fsm(clk, reset, clr_req, ptr, clr_en, busy, clr_done) owns the state and pointer.
- The top level owns the storage array, read muxing, bypass and write gating.

Test Plan:
- Basic write/read, default params: write 1<-CA, 7<-FE, 0<-DB. Then ra1=1, ra2=0 -> rd1=CA, rd2=00. Then ra2=7 -> rd2=FE.
- Bypass: we=1, wa=3, wd=5A, ra1=3 in the same cycle -> rd1=5A before the edge. Repeat with BYPASS=0 -> rd1=old value (00) until after the edge, then 5A.
- Bulk clear: load regs 1..7 with 11..77, pulse clr_req for one cycle -> busy high 8 cycles, clr_done high for 1 cycle on the 9th. Afterwards all reads = 00.
- Write during clear: at the 3rd busy cycle, we=1, wa=6, wd=AA -> wr_drop=1 that cycle. After done, rd(6)=00. A second clr_req held high through CLEAR starts no new sweep until IDLE.
- Reset mid-sweep: assert reset on the 4th busy cycle -> next cycle busy=0, clr_done never pulses, all registers 00, FSM idle. A fresh clr_req then completes normally.
- Parametrised: W=32, AW=5 -> write 31<-DEADBEEF reads back. Bulk clear busy lasts exactly 32 cycles. Register 0 reads 0 after a write of FFFFFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the parametrised register file
package regfile_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;
  localparam int REGFILE_W  = 8;
  localparam int REGFILE_AW = 3;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: one-register-per-cycle bulk-clear sequencer with busy/done handshake
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int AW = REGFILE_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic [AW-1:0] ptr,
  output logic          clr_en,
  output logic          busy,
  output logic          clr_done
);
  clr_state_t    r_state, w_state;
  logic [AW-1:0] r_ptr, w_ptr;
  // state and sweep pointer registers
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
    end
  // next state: requests only start a sweep from IDLE; the last register ends it
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    case (r_state)
      IDLE:    if (clr_req) begin
                 w_state = CLEAR;
                 w_ptr   = '0;
               end
      CLEAR:   begin
                 w_ptr   = r_ptr + 1'b1;
                 w_state = &r_ptr ? DONE : CLEAR;
               end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end
  assign ptr      = r_ptr;
  assign clr_en   = r_state == CLEAR;
  assign busy     = r_state == CLEAR;
  assign clr_done = r_state == DONE;
endmodule

// File: rtl/param_regfile.sv
// param_regfile: parametrised register file with async reads, write bypass and bulk clear
module param_regfile
  import regfile_pkg::*;
#(
  parameter int W        = REGFILE_W,
  parameter int AW       = REGFILE_AW,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_done,
  output logic          wr_drop
);
  localparam int DEPTH = 1 << AW;
  logic [W-1:0]  r_regs [DEPTH];
  logic [AW-1:0] w_ptr;
  logic          w_clr_en, w_wr_ok, w_byp1, w_byp2;
  regfile_clr_fsm #(.AW(AW)) u_fsm (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .ptr      (w_ptr),
    .clr_en   (w_clr_en),
    .busy     (busy),
    .clr_done (clr_done)
  );
  assign w_wr_ok = we & ~busy & ~(ZERO_REG & (wa == '0));
  assign w_byp1  = BYPASS & we & ~busy & (wa == ra1);
  assign w_byp2  = BYPASS & we & ~busy & (wa == ra2);
  assign rd1     = (ZERO_REG && ra1 == '0) ? '0 : w_byp1 ? wd : r_regs[ra1];
  assign rd2     = (ZERO_REG && ra2 == '0) ? '0 : w_byp2 ? wd : r_regs[ra2];
  assign wr_drop = we & busy;
  // storage: reset, then the clear sweep, then the write port
  always_ff @(posedge clk)
    if (reset) for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    else if (w_clr_en) r_regs[w_ptr] <= '0;
    else if (w_wr_ok) r_regs[wa] <= wd;
endmodule
